// File: rtl/mem_stage_hs_pkg.sv
// mem_stage_hs shared types: FSM state and the W-stage bundle.
// Widths below are the default build widths of mem_stage_hs.
package mem_stage_pkg;

  localparam int W_DATA = 19;
  localparam int W_ADDR = 19;
  localparam int W_RD   = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILL
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              resultsrc;
    logic [W_RD-1:0]   rd;
    logic [W_DATA-1:0] aluresult;
    logic [W_DATA-1:0] readdata;
    logic              err;
  } mem_w_t;

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory req/ack bus between mem_stage_hs and the memory.
// master = pipeline stage, slave = memory.
interface mem_stage_hs_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19
);
  logic              mem_req;
  logic              mem_we;
  logic              mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_byte,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_byte,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_stage_hs_wb.sv
// mem_wb_reg: async-reset MEM->WB register.
// Loads the completing instruction, otherwise a bubble.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  mem_w_t d_i,
  output mem_w_t q_o
);

  mem_w_t w_q;
  mem_w_t w_d;

  always_comb begin
    w_d = '0;
    if (load_i) w_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

  assign q_o = w_q;

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM->WB stage with req/ack data-memory handshake.
// Optional MEM_TIMEOUT_EN adds a TMO_CYC wait-cycle watchdog.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = W_DATA,
  parameter int ADDR_W  = W_ADDR,
  parameter int RD_W    = W_RD,
  parameter int TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_M,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic              Cant_ByteM,
  input  logic [RD_W-1:0]   RDM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              flush_M,
  output logic              stall_M,
  mem_stage_hs_if.master    mem,
  output logic              valid_W,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [RD_W-1:0]   RdW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              mem_err_W
);

  state_t state_q, state_d;
  logic   is_mem;
  logic   req;
  logic   ack;
  logic   tmo;
  logic   done;
  logic   err;
  mem_w_t wd;
  mem_w_t wq;
  logic [DATA_W-1:0] ld_data;

  assign ack    = mem.mem_ack;
  assign is_mem = valid_M & (MemWriteM | ResultSrcM);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo = (state_q != IDLE) &&
               (cnt_q == CNT_W'(TMO_CYC));

  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE && !ack && !tmo)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req  = is_mem & ~flush_M;
        done = valid_M & ~flush_M & (~is_mem | ack);
        if (req && !ack) state_d = WAIT;
      end
      WAIT: begin
        req = ~tmo;
        if (tmo) begin
          state_d = IDLE;
          done    = ~flush_M;
          err     = ~flush_M;
        end else if (ack) begin
          state_d = IDLE;
          done    = ~flush_M;
        end else if (flush_M) begin
          state_d = KILL;
        end
      end
      KILL: begin
        req = ~tmo;
        if (ack || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Gate with reset so the request drops the instant reset asserts.
  assign mem.mem_req  = req & reset;
  assign mem.mem_we   = MemWriteM;
  assign mem.mem_byte = Cant_ByteM;
  assign mem.mem_addr = ALUResultM[ADDR_W-1:0];
  assign mem.mem_wdata = Cant_ByteM ?
    {{(DATA_W-8){1'b0}}, WriteDataM[7:0]} :
    WriteDataM;

  assign stall_M = mem.mem_req & ~ack;

  assign ld_data = Cant_ByteM ?
    {{(DATA_W-8){1'b0}}, mem.mem_rdata[7:0]} :
    mem.mem_rdata;

  always_comb begin
    wd           = '0;
    wd.valid     = 1'b1;
    wd.regwrite  = RegWriteM & ~err;
    wd.resultsrc = ResultSrcM;
    wd.rd        = RDM;
    wd.aluresult = ALUResultM;
    wd.err       = err;
    if (ResultSrcM && !err) wd.readdata = ld_data;
  end

  mem_wb_reg u_wb (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (done),
    .d_i    (wd),
    .q_o    (wq)
  );

  assign valid_W    = wq.valid;
  assign RegWriteW  = wq.regwrite & wq.valid;
  assign ResultSrcW = wq.resultsrc;
  assign RdW        = wq.rd;
  assign ALUResultW = wq.aluresult;
  assign ReadDataW  = wq.readdata;
  assign mem_err_W  = wq.err;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs (define MEM_TIMEOUT_EN for
// the watchdog case, which then runs with TMO_CYC=4).
module tb_mem_stage_hs;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [18:0] alu;
    logic [18:0] rdd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M, RegWriteM, MemWriteM;
  logic        ResultSrcM, Cant_ByteM, flush_M;
  logic [4:0]  RDM;
  logic [18:0] ALUResultM, WriteDataM;
  logic        stall_M;
  logic        valid_W, RegWriteW, ResultSrcW;
  logic [4:0]  RdW;
  logic [18:0] ALUResultW, ReadDataW;
  logic        mem_err_W;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t me, ma;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.DATA_W(19), .ADDR_W(19)) mif ();

  mem_stage_hs #(
    .DATA_W(19), .ADDR_W(19), .RD_W(5), .TMO_CYC(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_M    (valid_M),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .Cant_ByteM (Cant_ByteM),
    .RDM        (RDM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .flush_M    (flush_M),
    .stall_M    (stall_M),
    .mem        (mif),
    .valid_W    (valid_W),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RdW        (RdW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .mem_err_W  (mem_err_W)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic clr_in();
    valid_M    = 1'b0;
    RegWriteM  = 1'b0;
    MemWriteM  = 1'b0;
    ResultSrcM = 1'b0;
    Cant_ByteM = 1'b0;
    flush_M    = 1'b0;
    RDM        = '0;
    ALUResultM = '0;
    WriteDataM = '0;
  endtask

  task automatic set_in(input logic we, bt, rw, ld,
                        input logic [4:0] rd,
                        input logic [18:0] a, wd);
    valid_M    = 1'b1;
    MemWriteM  = we;
    Cant_ByteM = bt;
    RegWriteM  = rw;
    ResultSrcM = ld;
    RDM        = rd;
    ALUResultM = a;
    WriteDataM = wd;
  endtask

  // Memory op acked after lat cycles; called at posedge+1.
  task automatic mem_op(input string nm,
                        input logic we, bt, rw,
                        input logic [4:0] rd,
                        input logic [18:0] a, wd,
                        input logic [18:0] rdat,
                        input int lat,
                        input logic [18:0] xwd,
                        input logic [18:0] xrd);
    exp_t x;
    set_in(we, bt, rw, ~we, rd, a, wd);
    x = {1'b1, rw, ~we, rd, a, xrd, 1'b0};
    q.push_back(x);
    mif.mem_ack = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk({nm, " stall"}, stall_M, 1);
      @(posedge clk); #1;
    end
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = rdat;
    #1;
    chk({nm, " stall0"}, stall_M, 0);
    chk({nm, " req"}, mif.mem_req, 1);
    chk({nm, " addr"}, mif.mem_addr, a);
    chk({nm, " we"}, mif.mem_we, we);
    chk({nm, " byte"}, mif.mem_byte, bt);
    chk({nm, " wdata"}, mif.mem_wdata, xwd);
    @(posedge clk); #1;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    clr_in();
  endtask

  always @(negedge clk) begin
    if (reset && valid_W) begin
      checks++;
      ma = {valid_W, RegWriteW, ResultSrcW, RdW,
            ALUResultW, ReadDataW, mem_err_W};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL w_unexpected act=%h req=none", ma);
      end else begin
        me = q.pop_front();
        if (ma !== me) begin
          errors++;
          $display("FAIL w_entry act=%h req=%h", ma, me);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

  initial begin
    exp_t x;
    int   cnt;
    reset         = 1'b0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    clr_in();
    set_in(0, 0, 1, 1, 5'd3, 19'h10, 19'h0);
    #12;
    chk("rst valid_W", valid_W, 0);
    chk("rst req", mif.mem_req, 0);
    chk("rst stall", stall_M, 0);
    chk("rst rdata_W", ReadDataW, 0);
    clr_in();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    set_in(0, 0, 1, 0, 5'd5, 19'h1234, 19'h0);
    x = {1'b1, 1'b1, 1'b0, 5'd5, 19'h1234, 19'h0, 1'b0};
    q.push_back(x);
    #1;
    chk("alu stall", stall_M, 0);
    chk("alu req", mif.mem_req, 0);
    @(posedge clk); #1;
    chk("alu valid_W", valid_W, 1);
    chk("alu RdW", RdW, 5);
    chk("alu ALUResultW", ALUResultW, 19'h1234);
    clr_in();

    mem_op("ldw", 0, 0, 1, 5'd7, 19'h40, 19'h0,
           19'h7ABCD, 3, 19'h0, 19'h7ABCD);
    mem_op("ldb", 0, 1, 1, 5'd8, 19'h44, 19'h0,
           19'h5A1FF, 0, 19'h0, 19'h000FF);
    mem_op("stb", 1, 1, 0, 5'd0, 19'h48, 19'h123C4,
           19'h7FFFF, 1, 19'h000C4, 19'h0);
    mem_op("stw", 1, 0, 0, 5'd0, 19'h4C, 19'h55AA5,
           19'h0, 0, 19'h55AA5, 19'h0);
    mem_op("b2b0", 0, 0, 1, 5'd12, 19'h70, 19'h0,
           19'h00001, 0, 19'h0, 19'h00001);
    mem_op("b2b1", 0, 0, 1, 5'd13, 19'h74, 19'h0,
           19'h40002, 0, 19'h0, 19'h40002);

    set_in(1, 0, 0, 0, 5'd0, 19'h50, 19'h11111);
    #1 chk("fl stall", stall_M, 1);
    @(posedge clk); #1 flush_M = 1'b1;
    #1 chk("fl req wait", mif.mem_req, 1);
    @(posedge clk); #1 flush_M = 1'b0;
    #1 chk("fl req kill", mif.mem_req, 1);
    chk("fl valid_W", valid_W, 0);
    @(posedge clk); #1 mif.mem_ack = 1'b1;
    #1 chk("fl req ack", mif.mem_req, 1);
    chk("fl we", mif.mem_we, 1);
    chk("fl stall0", stall_M, 0);
    @(posedge clk); #1 mif.mem_ack = 1'b0;
    chk("fl bubble", valid_W, 0);
    clr_in();
    set_in(0, 0, 1, 0, 5'd9, 19'h2222, 19'h0);
    x = {1'b1, 1'b1, 1'b0, 5'd9, 19'h2222, 19'h0, 1'b0};
    q.push_back(x);
    #1 chk("post fl stall", stall_M, 0);
    @(posedge clk); #1;
    chk("post fl valid_W", valid_W, 1);
    clr_in();

`ifdef MEM_TIMEOUT_EN
    set_in(0, 0, 1, 1, 5'd10, 19'h60, 19'h0);
    x = {1'b1, 1'b0, 1'b1, 5'd10, 19'h60, 19'h0, 1'b1};
    q.push_back(x);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!mif.mem_req) break;
      cnt++;
      @(posedge clk); #1;
    end
    chk("tmo req cycles", cnt, 5);
    chk("tmo stall0", stall_M, 0);
    @(posedge clk); #1;
    chk("tmo err_W", mem_err_W, 1);
    chk("tmo RegWriteW", RegWriteW, 0);
    clr_in();
`else
    cnt = 0;
`endif

    set_in(0, 0, 1, 1, 5'd11, 19'h64, 19'h0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("mid req pre", mif.mem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid req", mif.mem_req, 0);
    chk("mid stall", stall_M, 0);
    chk("mid valid_W", valid_W, 0);
    chk("mid RegWriteW", RegWriteW, 0);
    chk("mid RdW", RdW, 0);
    chk("mid ALUResultW", ALUResultW, 0);
    clr_in();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("post rst idle req", mif.mem_req, 0);
    chk("sb empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
